fpv_to_twos_seq: RTL and testbench

// - Sequential decoder for the 9-bit FPV format (S, E[2:0], F[4:0]) produced by FPCVT.
// - Rebuilds the 13-bit two's-complement value D = (S ? -1 : +1) * (F << E).
// - Sits downstream of FPCVT and uses valid/ready handshakes on both sides.
// - Default build shifts one bit per clock; the optional build uses a single-cycle barrel shift.

---
 rtl/fpv_to_twos_seq_if.sv | 26 ++
 rtl/fpv_to_twos_seq.sv | 101 ++++++++++
 tb/tb_fpv_to_twos_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpv_to_twos_seq_if.sv
// Handshake bundle for the FPV-to-two's-complement decoder.
// The upstream FPV word and the downstream result travel together.
interface fpv_to_twos_seq_if #(
  parameter int MANT_W = 5,
  parameter int EXP_W  = 3,
  parameter int OUT_W  = 13
);
  logic              in_valid;
  logic              in_ready;
  logic              S;
  logic [EXP_W-1:0]  E;
  logic [MANT_W-1:0] F;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  D;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D
  );
endinterface

// File: rtl/fpv_to_twos_seq.sv
// Sequential FPV (S,E,F) to two's-complement decoder: D = (S ? -1 : +1) * (F << E).
// Define FPV_FAST_SHIFT_EN for a single-cycle barrel shift instead of one bit per clock.
module fpv_to_twos_seq #(
  parameter int MANT_W = 5,
  parameter int EXP_W  = 3,
  parameter int OUT_W  = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  fpv_to_twos_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, HOLD} state_t;

  localparam logic [EXP_W-1:0] CNT_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    d_d         = d_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mag_d      = {{(OUT_W-MANT_W){1'b0}}, bus.F};
          cnt_d      = bus.E;
          sgn_d      = bus.S;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
`ifdef FPV_FAST_SHIFT_EN
        mag_d   = mag_q << cnt_q;
        cnt_d   = '0;
        state_d = SIGN;
`else
        // The final SHIFT cycle (cnt==0) only advances the state, giving E+1 cycles here.
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = SIGN;
        end
`endif
      end
      SIGN: begin
        d_d         = sgn_q ? (~mag_q + OUT_ONE) : mag_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      d_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
endmodule

// File: tb/tb_fpv_to_twos_seq.sv
// Randomised self-checking bench for fpv_to_twos_seq against an arithmetic model.
// Latency expectations follow FPV_FAST_SHIFT_EN when it is defined.
module tb_fpv_to_twos_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpv_to_twos_seq_if #(.MANT_W(5), .EXP_W(3), .OUT_W(13)) bus ();

  fpv_to_twos_seq #(.MANT_W(5), .EXP_W(3), .OUT_W(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

`ifdef FPV_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  function automatic logic [12:0] ref_d(input bit s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return 13'(v);
  endfunction

  function automatic int ref_lat(input int e);
    return FAST ? 3 : e + 3;
  endfunction

  // One full transaction; lat counts posedges from the accept edge (inclusive)
  // to the first out_valid, or -1 on timeout.
  task automatic do_txn(input bit s, input int e, input int f, input int stall,
                        output logic [12:0] d, output int lat,
                        output bit stable, output bit hs_ok);
    int guard;
    d = 'x; stable = 1'b0; hs_ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.S = s; bus.E = 3'(e); bus.F = 5'(f);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.S = 1'($urandom); bus.E = 3'($urandom); bus.F = 5'($urandom);
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      bus.out_ready = 1'($urandom);
      @(posedge clk);
      lat++;
    end
    if (lat >= 40) begin
      lat = -1;
      bus.out_ready = 1'b0;
      return;
    end
    d = bus.D;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      if (bus.D !== d || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    hs_ok = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.D !== 13'd0) begin
      failures++;
      $display("FAIL reset_D: got %h required 0000", bus.D);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    bit          ts[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    int          te[4]  = '{1, 7, 0, 3};
    int          tf[4]  = '{29, 31, 0, 14};
    int          tst[4] = '{0, 0, 0, 12};
    logic [12:0] td[4]  = '{13'h003A, 13'h1080, 13'h0000, 13'd112};
    logic [12:0] d;
    int lat;
    bit stable, hs_ok;
    for (int i = 0; i < 4; i++) begin
      do_txn(ts[i], te[i], tf[i], tst[i], d, lat, stable, hs_ok);
      $display("directed %0d: S=%0d E=%0d F=%0d -> D=%h lat=%0d", i, ts[i], te[i], tf[i], d, lat);
      checks++;
      if (d !== td[i]) begin
        failures++;
        $display("FAIL directed_D[%0d]: got %h required %h", i, d, td[i]);
      end
      checks++;
      if (lat != ref_lat(te[i])) begin
        failures++;
        $display("FAIL directed_lat[%0d]: got %0d required %0d", i, lat, ref_lat(te[i]));
      end
      checks++;
      if (!stable) begin
        failures++;
        $display("FAIL directed_hold[%0d]: stable=%b required 1", i, stable);
      end
      checks++;
      if (!hs_ok) begin
        failures++;
        $display("FAIL directed_handshake[%0d]: idle_after=%b required 1", i, hs_ok);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int guard;
    logic [12:0] d;
    int lat;
    bit stable, hs_ok, quiet;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.S = 1'b0; bus.E = 3'd7; bus.F = 5'b10000;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.D !== 13'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_async: out_valid=%b D=%h in_ready=%b, required 0/0000/1",
               bus.out_valid, bus.D, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL midreset_aborted: stale result emitted, quiet=%b required 1", quiet);
    end
    do_txn(1'b0, 2, 21, 1, d, lat, stable, hs_ok);
    $display("post-reset: S=0 E=2 F=21 -> D=%h lat=%0d", d, lat);
    checks++;
    if (d !== ref_d(1'b0, 2, 21) || lat != ref_lat(2)) begin
      failures++;
      $display("FAIL midreset_next: D=%h lat=%0d required D=%h lat=%0d", d, lat, ref_d(1'b0, 2, 21), ref_lat(2));
    end
  endtask

  task automatic test_random();
    logic [12:0] d;
    int lat, e, f, stall;
    bit s, stable, hs_ok;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom); e = $urandom_range(0, 7); f = $urandom_range(0, 31); stall = $urandom_range(0, 3);
      do_txn(s, e, f, stall, d, lat, stable, hs_ok);
      $display("random %0d: S=%0d E=%0d F=%0d stall=%0d -> D=%h lat=%0d", i, s, e, f, stall, d, lat);
      checks++;
      if (d !== ref_d(s, e, f)) begin
        failures++;
        $display("FAIL random_D[%0d]: got %h required %h", i, d, ref_d(s, e, f));
      end
      checks++;
      if (lat != ref_lat(e) || !stable || !hs_ok) begin
        failures++;
        $display("FAIL random_timing[%0d]: lat=%0d stable=%b idle=%b required lat=%0d 1 1",
                 i, lat, stable, hs_ok, ref_lat(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    bit          qs[N];
    int          qe[N], qf[N];
    logic [12:0] got[$];
    int idx, cyc;
    bit acc;
    for (int i = 0; i < N; i++) begin
      qs[i] = 1'($urandom); qe[i] = $urandom_range(0, 7); qf[i] = $urandom_range(0, 31);
    end
    idx = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (cyc < 400 && (got.size() < N || cyc < 20 + N * 11)) begin
      @(negedge clk);
      acc = 1'b0;
      if (idx < N) begin
        bus.in_valid = 1'b1; bus.S = qs[idx]; bus.E = 3'(qe[idx]); bus.F = 5'(qf[idx]);
        acc = (bus.in_ready === 1'b1);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) got.push_back(bus.D);
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (got.size() != N) begin
      failures++;
      $display("FAIL b2b_count: got %0d results required %0d", got.size(), N);
    end
    for (int i = 0; i < N && i < got.size(); i++) begin
      $display("b2b %0d: S=%0d E=%0d F=%0d -> D=%h", i, qs[i], qe[i], qf[i], got[i]);
      checks++;
      if (got[i] !== ref_d(qs[i], qe[i], qf[i])) begin
        failures++;
        $display("FAIL b2b_D[%0d]: got %h required %h", i, got[i], ref_d(qs[i], qe[i], qf[i]));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.S = 1'b0; bus.E = '0; bus.F = '0;
    test_reset();
    test_directed();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
